// File: rtl/week_tally.sv
// Downstream monitor of a mod-7 day counter: registered one-hot day decode,
// week accumulation on each 6->0 wrap, and a sticky illegal-code/step flag.
module week_tally #(
    parameter int W   = 6,
    parameter int MOD = 52
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [2:0]   CNT,
    input  logic         ERR_CLR,
    output logic [6:0]   DAY,
    output logic [W-1:0] WEEK,
    output logic         WRAP,
    output logic         WEEK_WRAP,
    output logic         ERR
);

    localparam logic [W-1:0] LP_LAST = W'(MOD - 1);

    logic [2:0]   r_prev_cnt;
    logic         r_prev_vld;
    logic [6:0]   r_day;
    logic [W-1:0] r_week;
    logic         r_wrap;
    logic         r_week_wrap;
    logic         r_err;

    logic [2:0]   w_succ;
    logic         w_step_ok;
    logic         w_e_code;
    logic         w_e_step;
    logic         w_wrap_det;
    logic [6:0]   w_day;

    always_comb begin
        w_succ     = (r_prev_cnt == 3'd6) ? 3'd0 : r_prev_cnt + 3'd1;
        w_step_ok  = (CNT == r_prev_cnt) || (CNT == w_succ);
        w_e_code   = (CNT == 3'd7);
        // a 7 has already been flagged, so the step out of it is not checked
        w_e_step   = r_prev_vld && (r_prev_cnt != 3'd7) && !w_e_code && !w_step_ok;
        w_wrap_det = r_prev_vld && (r_prev_cnt == 3'd6) && (CNT == 3'd0);
        // code 7 shifts the bit out of the 7-bit field, giving an all-zero decode
        w_day      = 7'd1 << CNT;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prev_cnt  <= '0;
            r_prev_vld  <= 1'b0;
            r_day       <= '0;
            r_week      <= '0;
            r_wrap      <= 1'b0;
            r_week_wrap <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_prev_cnt  <= CNT;
            r_prev_vld  <= 1'b1;
            r_day       <= w_day;
            r_wrap      <= w_wrap_det;
            r_week_wrap <= 1'b0;
            if (w_wrap_det) begin
                if (r_week == LP_LAST) begin
                    r_week      <= '0;
                    r_week_wrap <= 1'b1;
                end else begin
                    r_week <= r_week + 1'b1;
                end
            end
            if (w_e_code || w_e_step) begin
                r_err <= 1'b1;
            end else if (ERR_CLR) begin
                r_err <= 1'b0;
            end
        end
    end

    assign DAY       = r_day;
    assign WEEK      = r_week;
    assign WRAP      = r_wrap;
    assign WEEK_WRAP = r_week_wrap;
    assign ERR       = r_err;

endmodule

// File: tb/tb_week_tally.sv
// Directed vector bench for week_tally with W=2, MOD=4 (rollover at full width).
module tb_week_tally;

    logic       clk;
    logic       rst;
    logic [2:0] cnt;
    logic       err_clr;
    logic [6:0] day;
    logic [1:0] week;
    logic       wrap;
    logic       week_wrap;
    logic       err;

    int total;
    int bad;

    week_tally #(.W(2), .MOD(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .CNT       (cnt),
        .ERR_CLR   (err_clr),
        .DAY       (day),
        .WEEK      (week),
        .WRAP      (wrap),
        .WEEK_WRAP (week_wrap),
        .ERR       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] cnt;
        logic       clr;
        logic [6:0] day;
        logic [1:0] week;
        logic       wrap;
        logic       ww;
        logic       err;
    } vec_t;

    vec_t tv[$];

    task automatic add(input logic [2:0] c, input logic cl, input logic [6:0] d,
                       input logic [1:0] wk, input logic wr, input logic w2, input logic e);
        vec_t v;
        v.cnt = c; v.clr = cl; v.day = d; v.week = wk; v.wrap = wr; v.ww = w2; v.err = e;
        tv.push_back(v);
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [6:0] d, input logic [1:0] wk,
                           input logic wr, input logic w2, input logic e);
        chk({tag, ".DAY"},       int'(day),       int'(d));
        chk({tag, ".WEEK"},      int'(week),      int'(wk));
        chk({tag, ".WRAP"},      int'(wrap),      int'(wr));
        chk({tag, ".WEEK_WRAP"}, int'(week_wrap), int'(w2));
        chk({tag, ".ERR"},       int'(err),       int'(e));
    endtask

    task automatic step(input logic [2:0] c, input logic cl);
        cnt     = c;
        err_clr = cl;
        @(posedge clk);
        #1;
    endtask

    localparam logic [6:0] D0 = 7'b0000001;
    localparam logic [6:0] D1 = 7'b0000010;
    localparam logic [6:0] D2 = 7'b0000100;
    localparam logic [6:0] D3 = 7'b0001000;
    localparam logic [6:0] D4 = 7'b0010000;
    localparam logic [6:0] D5 = 7'b0100000;
    localparam logic [6:0] D6 = 7'b1000000;
    localparam logic [6:0] DZ = 7'b0000000;

    initial begin
        int seq[$];
        total = 0;
        bad   = 0;

        //   cnt clr day week wrap ww err
        add(0, 0, D0, 0, 0, 0, 0);  // priming edge
        add(1, 0, D1, 0, 0, 0, 0);
        add(2, 0, D2, 0, 0, 0, 0);
        add(3, 0, D3, 0, 0, 0, 0);
        add(4, 0, D4, 0, 0, 0, 0);
        add(5, 0, D5, 0, 0, 0, 0);
        add(6, 0, D6, 0, 0, 0, 0);
        add(0, 0, D0, 1, 1, 0, 0);  // first wrap
        add(1, 0, D1, 1, 0, 0, 0);
        add(2, 0, D2, 1, 0, 0, 0);
        add(3, 0, D3, 1, 0, 0, 0);
        add(4, 0, D4, 1, 0, 0, 0);
        add(5, 0, D5, 1, 0, 0, 0);
        add(6, 0, D6, 1, 0, 0, 0);  // hold 6 for five cycles
        add(6, 0, D6, 1, 0, 0, 0);
        add(6, 0, D6, 1, 0, 0, 0);
        add(6, 0, D6, 1, 0, 0, 0);
        add(6, 0, D6, 1, 0, 0, 0);
        add(0, 0, D0, 2, 1, 0, 0);
        add(1, 0, D1, 2, 0, 0, 0);
        add(2, 0, D2, 2, 0, 0, 0);
        add(3, 0, D3, 2, 0, 0, 0);
        add(4, 0, D4, 2, 0, 0, 0);
        add(5, 0, D5, 2, 0, 0, 0);
        add(6, 0, D6, 2, 0, 0, 0);
        add(0, 0, D0, 3, 1, 0, 0);
        add(1, 0, D1, 3, 0, 0, 0);
        add(2, 0, D2, 3, 0, 0, 0);
        add(3, 0, D3, 3, 0, 0, 0);
        add(4, 0, D4, 3, 0, 0, 0);
        add(5, 0, D5, 3, 0, 0, 0);
        add(6, 0, D6, 3, 0, 0, 0);
        add(0, 0, D0, 0, 1, 1, 0);  // week count rollover
        add(1, 0, D1, 0, 0, 0, 0);
        add(2, 0, D2, 0, 0, 0, 0);
        add(7, 0, DZ, 0, 0, 0, 1);  // illegal code
        add(0, 0, D0, 0, 0, 0, 1);  // 7->0: no wrap, no extra step error
        add(1, 0, D1, 0, 0, 0, 1);
        add(2, 0, D2, 0, 0, 0, 1);
        add(3, 1, D3, 0, 0, 0, 0);  // clear with legal step
        add(4, 0, D4, 0, 0, 0, 0);
        add(5, 0, D5, 0, 0, 0, 0);
        add(6, 0, D6, 0, 0, 0, 0);
        add(0, 0, D0, 1, 1, 0, 0);
        add(1, 0, D1, 1, 0, 0, 0);
        add(2, 0, D2, 1, 0, 0, 0);
        add(5, 0, D5, 1, 0, 0, 1);  // 2->5 step violation
        add(6, 1, D6, 1, 0, 0, 0);
        add(0, 0, D0, 2, 1, 0, 0);
        add(1, 0, D1, 2, 0, 0, 0);
        add(2, 0, D2, 2, 0, 0, 0);
        add(3, 0, D3, 2, 0, 0, 0);
        add(1, 1, D1, 2, 0, 0, 1);  // 3->1 jump beats ERR_CLR
        add(2, 0, D2, 2, 0, 0, 1);
        add(3, 1, D3, 2, 0, 0, 0);
        add(4, 0, D4, 2, 0, 0, 0);
        add(5, 0, D5, 2, 0, 0, 0);
        add(6, 0, D6, 2, 0, 0, 0);
        add(7, 0, DZ, 2, 0, 0, 1);  // 6->7->0 is not a wrap
        add(0, 0, D0, 2, 0, 0, 1);
        add(1, 1, D1, 2, 0, 0, 0);

        rst     = 1'b1;
        cnt     = 3'd0;
        err_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_all("reset", DZ, 0, 0, 0, 0);
        rst = 1'b0;

        for (int i = 0; i < tv.size(); i++) begin
            step(tv[i].cnt, tv[i].clr);
            chk_all($sformatf("vec%0d", i), tv[i].day, tv[i].week, tv[i].wrap, tv[i].ww, tv[i].err);
        end

        // build WEEK=3, CNT=6, ERR=1, then reset mid-cycle
        seq = '{2, 3, 4, 5, 6, 0, 1, 2, 3, 5, 6};
        foreach (seq[k]) step(3'(seq[k]), 1'b0);
        chk_all("pre_rst", D6, 3, 0, 0, 1);
        #2;
        rst = 1'b1;
        #1;
        chk_all("async_rst", DZ, 0, 0, 0, 0);
        cnt = 3'd0;
        @(posedge clk);
        #1;
        chk_all("held_rst", DZ, 0, 0, 0, 0);
        rst = 1'b0;
        step(0, 0);
        chk_all("post_rst", D0, 0, 0, 0, 0);
        step(1, 0);
        chk_all("post_rst1", D1, 0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
